toggle_event_receiver: RTL
==========================

# toggle_event_receiver

Receiving end of the toggle-signalling scheme built on the T flip-flop: a transmitter flips a T-FF output once per event, and this block turns each level change back into an event. It synchronizes the toggle line, emits one single-cycle pulse per detected toggle, and queues events in a saturating pending counter that a consumer drains through a valid/ready handshake. It sits beside any block that reports events as a toggling level, such as status or completion lines.

## Interface
- SYNC_STAGES, 2, synchronizer depth on `t_in` (legal values ≥ 2).
- CNT_WIDTH, 4, width of the pending-event counter (legal values ≥ 2).

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on `clk` rising edge.
- t_in  input  1  toggle line from the transmitter T-FF; each level change is one event.
- evt_pulse  output  1  high for exactly one cycle per detected toggle.
- evt_valid  output  1  high while `pending` ≠ 0.
- evt_ready  input  1  consumer accepts one event when `evt_valid && evt_ready`.
- pending  output  CNT_WIDTH  number of unconsumed events.
- overflow  output  1  sticky; an event arrived while `pending` was saturated and was not consumed.
- clr_ovf  input  1  clears `overflow`.

## Operation
- Reset (`reset`=0 at an edge): all synchronizer stages, the previous-sample register, `evt_pulse`, `pending` and `overflow` go to 0, so `evt_valid` is 0. The transmitter T-FF also resets to 0, so no spurious event is produced.
- Detect: `sync[N-1]` is compared with `prev`, and `prev` loads `sync[N-1]` every edge. A mismatch means a toggle. N = SYNC_STAGES.
- `evt_pulse` is the registered mismatch. The line may toggle on every clock, and each toggle yields one pulse, so back-to-back toggles give back-to-back pulses.
- Counter update, using inc = registered mismatch and pop = `evt_valid && evt_ready`:
  - inc and pop: unchanged.
  - inc only: +1, saturating at 2^CNT_WIDTH−1.
  - pop only: −1.
  - `evt_ready` while `pending`=0 is ignored, so there is no underflow.
- Overflow: set when inc occurs with `pending` = max and no pop. Cleared by `clr_ovf`. If set and clear happen in the same cycle, set wins.
- `evt_ready` may be held high permanently; the consumer then drains one event per cycle.

## Timing
- Let edge k be the first edge to sample a new `t_in` level.
- `evt_pulse` is high during the cycle after edge k+N. The latency is N+1 edges, which is 3 at the default.
- `pending` increments at the same edge k+N. `evt_valid` is therefore high from that same cycle.
- A pop takes effect at the edge where `evt_valid && evt_ready` is sampled. `pending` and `evt_valid` update after that edge.
- `overflow` is registered and asserts at the overflowing edge.
- Reset mid-operation: every output is 0 after the reset edge. Toggles in flight inside the synchronizer are discarded.
- No combinational path from any input to any output.

## Structure
- Shared package or header holds:
  - `CNT_MAX` = 2^CNT_WIDTH−1, derived locally from the parameter.
  - Default constants `TOGGLE_SYNC_STAGES_DEF`=2 and `TOGGLE_CNT_WIDTH_DEF`=4, also used by the transmitter side.
- One sub-module, `toggle_sync`: a parameterized N-stage reset-to-0 flop chain, reused by other toggle receivers.
- The detect register, counter and overflow logic sit in the top module. No FSM states are needed beyond the counter.

## Test plan
- Reset with `t_in`=0, then release → `evt_pulse`=0, `evt_valid`=0, `pending`=0, `overflow`=0 for 10 cycles with no activity.
- `t_in` 0→1 sampled at edge k, `evt_ready`=0 → one `evt_pulse` in the cycle after edge k+2; `pending`=1; `evt_valid`=1. Then one `evt_ready` cycle → `pending`=0 and `evt_valid`=0 after that edge.
- `t_in` toggled on 5 consecutive edges, `evt_ready`=0 → 5 consecutive `evt_pulse` cycles; `pending`=5.
- 16 toggles with `evt_ready`=0 → `pending` saturates at 15 and `overflow`=1 on the 16th. Pulse `clr_ovf` → `overflow`=0 and `pending` stays 15.
- With `pending`=3, `evt_ready`=1 held while one toggle arrives → `pending` stays 3 on the increment edge, then drains 3→2→1→0.
- With `pending`=7 and `overflow`=1, `reset`=0 for one edge → all outputs 0 next cycle. A toggle still inside the synchronizer produces no pulse.

Source files
------------

// File: rtl/toggle_event_receiver_pkg.sv
// Shared defaults and counter-action encoding for toggle-signalling receivers.
// The transmitter side imports the same defaults so both ends agree on depth and width.
package toggle_event_receiver_pkg;

    localparam int unsigned TOGGLE_SYNC_STAGES_DEF = 2;
    localparam int unsigned TOGGLE_CNT_WIDTH_DEF   = 4;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // A simultaneous arrival and consume cancel out.
    function automatic cnt_op_e cnt_op(input logic inc, input logic pop);
        cnt_op_e op;
        op = CNT_HOLD;
        if (inc && !pop) begin
            op = CNT_INC;
        end else if (!inc && pop) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/toggle_event_receiver_if.sv
// Event-side bundle of the toggle receiver: toggle input, pulse, pending count,
// valid/ready drain handshake and sticky overflow.
interface toggle_event_receiver_if
    import toggle_event_receiver_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = TOGGLE_CNT_WIDTH_DEF
);
    logic                 t_in;
    logic                 evt_pulse;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [CNT_WIDTH-1:0] pending;
    logic                 overflow;
    logic                 clr_ovf;

    modport master (
        output t_in,
        output evt_ready,
        output clr_ovf,
        input  evt_pulse,
        input  evt_valid,
        input  pending,
        input  overflow
    );

    modport slave (
        input  t_in,
        input  evt_ready,
        input  clr_ovf,
        output evt_pulse,
        output evt_valid,
        output pending,
        output overflow
    );

endinterface

// File: rtl/toggle_event_receiver_sync.sv
// toggle_sync: N-stage reset-to-0 flop chain bringing an asynchronous toggle
// level into the clk domain; shared by the toggle receivers.
module toggle_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Toggle-to-event receiver: synchronizes t_in, pulses once per level change and
// queues events in a saturating pending counter drained through valid/ready.
module toggle_event_receiver
    import toggle_event_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = TOGGLE_SYNC_STAGES_DEF,
    parameter int unsigned CNT_WIDTH   = TOGGLE_CNT_WIDTH_DEF
) (
    input logic                    clk,
    input logic                    reset,
    toggle_event_receiver_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 synced;
    logic                 prev;
    logic                 mismatch;
    logic                 pulse_q;
    logic                 pop;
    logic                 sat;
    cnt_op_e              op;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;

    toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.t_in),
        .q     (synced)
    );

    assign mismatch = synced ^ prev;
    assign pop      = (cnt_q != '0) && bus.evt_ready;
    assign sat      = (cnt_q == CNT_MAX);
    assign op       = cnt_op(mismatch, pop);

    // The mismatch is counted at the same edge that registers it as evt_pulse,
    // so pending and evt_valid rise together with the pulse.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unique case (op)
            CNT_INC: if (!sat) cnt_d = cnt_q + 1'b1;
            CNT_DEC: cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (op == CNT_INC && sat) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev    <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            prev    <= synced;
            pulse_q <= mismatch;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.evt_pulse = pulse_q;
    assign bus.evt_valid = (cnt_q != '0);
    assign bus.pending   = cnt_q;
    assign bus.overflow  = ovf_q;

endmodule
